// File: rtl/irq_router_pkg.sv
// Shared definitions for the dock interrupt router: entry field layout,
// router state encoding and the routing-table address map.
package irq_router_pkg;

  localparam int EN_BIT  = 7;
  localparam int IDX_MSB = 3;
  // Only the enable bit and the pin index are kept; bits 6:4 read back as 0.
  localparam logic [7:0] ENTRY_MASK = 8'h8F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NMI  = 2'd1,
    ST_INT  = 2'd2
  } irq_state_e;

  function automatic int int_addr(int slot, int ch, int num_ch);
    return slot * num_ch + ch;
  endfunction

  function automatic int nmi_addr(int slot, int num_slots, int num_ch);
    return num_slots * num_ch + slot;
  endfunction

endpackage

// File: rtl/irq_route_table.sv
// Routing-table registers: one masked 8-bit entry per INT/NMI source,
// a combinational read port, and per-source enable/pin-index exports.
module irq_route_table
  import irq_router_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_TILE_INT_CH = 2,
  parameter int CFG_ADDR_WIDTH  = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 cfg_wr_en,
  input  logic                                                 cfg_rd_en,
  input  logic [CFG_ADDR_WIDTH-1:0]                            cfg_addr,
  input  logic [7:0]                                           cfg_wdata,
  output logic [31:0]                                          cfg_rdata,
  output logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0]                 int_en,
  output logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0][IDX_MSB:0]      int_idx,
  output logic [NUM_SLOTS-1:0]                                 nmi_en,
  output logic [NUM_SLOTS-1:0][IDX_MSB:0]                      nmi_idx
);

  localparam int NI      = NUM_SLOTS * NUM_TILE_INT_CH;
  localparam int NUM_ENT = NUM_SLOTS * (NUM_TILE_INT_CH + 1);

  logic [NUM_ENT-1:0][7:0] ent;
  logic [NUM_ENT-1:0]      hit;

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
    // Out-of-range addresses match no entry, so such writes fall away.
    assign hit[i] = (cfg_addr == CFG_ADDR_WIDTH'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  ent[i] <= 8'h00;
      else if (cfg_wr_en && hit[i]) ent[i] <= cfg_wdata & ENTRY_MASK;
    end
  end

  always_comb begin
    cfg_rdata = 32'h0;
    for (int i = 0; i < NUM_ENT; i++)
      if (cfg_rd_en && hit[i]) cfg_rdata = {24'h0, ent[i]};
  end

  for (genvar i = 0; i < NI; i++) begin : g_int
    assign int_en[i]  = ent[i][EN_BIT];
    assign int_idx[i] = ent[i][IDX_MSB:0];
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_nmi
    assign nmi_en[s]  = ent[NI+s][EN_BIT];
    assign nmi_idx[s] = ent[NI+s][IDX_MSB:0];
  end

endmodule

// File: rtl/dock_irq_router.sv
// Dock interrupt router: picks one eligible INT/NMI source at a time
// (NMI first, then lowest index), drives its CPU pin and steers the ack.
module dock_irq_router
  import irq_router_pkg::*;
#(
  parameter  int NUM_SLOTS       = 4,
  parameter  int NUM_CPU_INT     = 2,
  parameter  int NUM_CPU_NMI     = 1,
  parameter  int NUM_TILE_INT_CH = 2,
  parameter  int CFG_ADDR_WIDTH  = 8,
  localparam int SLOT_IDX_WIDTH  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_clk,
  input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0]  tile_int_req,
  input  logic [NUM_SLOTS-1:0]                  tile_nmi_req,
  input  logic                                  irq_ack,
  output logic [NUM_CPU_INT-1:0]                cpu_int,
  output logic [NUM_CPU_NMI-1:0]                cpu_nmi,
  output logic [NUM_SLOTS-1:0]                  slot_ack,
  output logic                                  irq_int_active,
  output logic [SLOT_IDX_WIDTH-1:0]             irq_int_slot,
  input  logic                                  cfg_wr_en,
  input  logic                                  cfg_rd_en,
  input  logic [CFG_ADDR_WIDTH-1:0]             cfg_addr,
  input  logic [31:0]                           cfg_wdata,
  output logic [31:0]                           cfg_rdata
);

  localparam int NI = NUM_SLOTS * NUM_TILE_INT_CH;

  logic                          unused_ok;
  logic [NI-1:0]                 int_en;
  logic [NI-1:0][IDX_MSB:0]      int_idx;
  logic [NUM_SLOTS-1:0]          nmi_en;
  logic [NUM_SLOTS-1:0][IDX_MSB:0] nmi_idx;

  assign unused_ok = &{1'b0, cfg_clk, cfg_wdata[31:8]};

  irq_route_table #(
    .NUM_SLOTS       (NUM_SLOTS),
    .NUM_TILE_INT_CH (NUM_TILE_INT_CH),
    .CFG_ADDR_WIDTH  (CFG_ADDR_WIDTH)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_wr_en (cfg_wr_en),
    .cfg_rd_en (cfg_rd_en),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata[7:0]),
    .cfg_rdata (cfg_rdata),
    .int_en    (int_en),
    .int_idx   (int_idx),
    .nmi_en    (nmi_en),
    .nmi_idx   (nmi_idx)
  );

  irq_state_e           state, state_nx;
  logic [NI-1:0]        act_int, act_int_nx, int_elig, int_cand, int_pick;
  logic [NUM_SLOTS-1:0] act_nmi, act_nmi_nx, nmi_elig, nmi_cand, nmi_pick;
  logic [IDX_MSB:0]     act_idx, act_idx_nx, pick_int_idx, pick_nmi_idx;
  logic                 released;

  assign int_elig = tile_int_req & int_en;
  assign nmi_elig = tile_nmi_req & nmi_en;
  assign int_cand = int_elig & ~act_int;
  assign nmi_cand = nmi_elig & ~act_nmi;
  // Isolate lowest set bit: lowest index has priority.
  assign int_pick = int_cand & (~int_cand + NI'(1));
  assign nmi_pick = nmi_cand & (~nmi_cand + NUM_SLOTS'(1));

  always_comb begin
    pick_int_idx = '0;
    pick_nmi_idx = '0;
    for (int i = 0; i < NI; i++)
      if (int_pick[i]) pick_int_idx = int_idx[i];
    for (int s = 0; s < NUM_SLOTS; s++)
      if (nmi_pick[s]) pick_nmi_idx = nmi_idx[s];
  end

  always_comb begin
    case (state)
      ST_INT:  released = ~|(act_int & int_elig);
      ST_NMI:  released = ~|(act_nmi & nmi_elig);
      default: released = 1'b1;
    endcase
    state_nx   = state;
    act_int_nx = act_int;
    act_nmi_nx = act_nmi;
    act_idx_nx = act_idx;
    // Reselection only happens when the slot frees up, so no preemption.
    if (released) begin
      act_int_nx = '0;
      act_nmi_nx = '0;
      act_idx_nx = '0;
      if (|nmi_cand) begin
        state_nx   = ST_NMI;
        act_nmi_nx = nmi_pick;
        act_idx_nx = pick_nmi_idx;
      end else if (|int_cand) begin
        state_nx   = ST_INT;
        act_int_nx = int_pick;
        act_idx_nx = pick_int_idx;
      end else begin
        state_nx   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      act_int <= '0;
      act_nmi <= '0;
      act_idx <= '0;
    end else begin
      state   <= state_nx;
      act_int <= act_int_nx;
      act_nmi <= act_nmi_nx;
      act_idx <= act_idx_nx;
    end
  end

  assign irq_int_active = (state == ST_INT);

  always_comb begin
    irq_int_slot = '0;
    for (int i = 0; i < NI; i++)
      if (act_int[i]) irq_int_slot = SLOT_IDX_WIDTH'(i / NUM_TILE_INT_CH);
  end

  // Pin indices beyond the pin count match nothing and drive no pin.
  always_comb begin
    for (int p = 0; p < NUM_CPU_INT; p++)
      cpu_int[p] = irq_int_active && (act_idx == (IDX_MSB+1)'(p));
    for (int p = 0; p < NUM_CPU_NMI; p++)
      cpu_nmi[p] = (state == ST_NMI) && (act_idx == (IDX_MSB+1)'(p));
    for (int s = 0; s < NUM_SLOTS; s++)
      slot_ack[s] = irq_ack && irq_int_active && (irq_int_slot == SLOT_IDX_WIDTH'(s));
  end

endmodule

// File: tb/tb_dock_irq_router.sv
// Directed bench for dock_irq_router with 3 slots, 2 INT pins, 1 NMI pin.
module tb_dock_irq_router;

  logic        clk = 1'b0;
  logic        rst_n, cfg_clk;
  logic [5:0]  tile_int_req;
  logic [2:0]  tile_nmi_req;
  logic        irq_ack;
  logic [1:0]  cpu_int;
  logic [0:0]  cpu_nmi;
  logic [2:0]  slot_ack;
  logic        irq_int_active;
  logic [1:0]  irq_int_slot;
  logic        cfg_wr_en, cfg_rd_en;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign cfg_clk = clk;

  dock_irq_router #(
    .NUM_SLOTS(3), .NUM_CPU_INT(2), .NUM_CPU_NMI(1),
    .NUM_TILE_INT_CH(2), .CFG_ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_clk(cfg_clk),
    .tile_int_req(tile_int_req), .tile_nmi_req(tile_nmi_req), .irq_ack(irq_ack),
    .cpu_int(cpu_int), .cpu_nmi(cpu_nmi), .slot_ack(slot_ack),
    .irq_int_active(irq_int_active), .irq_int_slot(irq_int_slot),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr_en = 1'b0; cfg_wdata = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cfg_rd_en = 1'b1; cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
    cfg_rd_en = 1'b0;
  endtask

  task automatic ack_chk(input string tag, input logic [2:0] exp);
    irq_ack = 1'b1;
    #1;
    chk(tag, {29'h0, slot_ack}, {29'h0, exp});
    irq_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; tile_int_req = '0; tile_nmi_req = '0; irq_ack = 1'b0;
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    step(); step();
    chk("rst_outs", {25'h0, cpu_int, cpu_nmi, slot_ack, irq_int_active},  32'h0);
    chk("rst_slot", {30'h0, irq_int_slot}, 32'h0);
    rst_n = 1'b1;
    step();
    rd_chk("rst_rd0", 8'd0, 32'h0);

    // table write masking / range
    wr(8'd1, 32'hFFFF_FFFF);
    rd_chk("mask_rd1", 8'd1, 32'h8F);
    wr(8'd9, 32'hFF);
    rd_chk("oor_rd9", 8'd9, 32'h0);
    cfg_rd_en = 1'b0; cfg_addr = 8'd1; #1;
    chk("rd_noen", cfg_rdata, 32'h0);
    wr(8'd1, 32'h0);

    // single INT, ack does not release
    wr(8'd0, 32'h80);
    tile_int_req[0] = 1'b1;
    step();
    chk("int0_pin", {30'h0, cpu_int}, 32'h1);
    chk("int0_act", {31'h0, irq_int_active}, 32'h1);
    ack_chk("int0_ack", 3'b001);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("int0_hold", {30'h0, cpu_int}, 32'h1);
    tile_int_req[0] = 1'b0;
    step();
    chk("int0_drop", {30'h0, cpu_int}, 32'h0);
    chk("int0_inact", {31'h0, irq_int_active}, 32'h0);
    ack_chk("idle_ack", 3'b000);

    // NMI beats INT, then INT follows on the release edge
    wr(8'd7, 32'h80);
    tile_nmi_req[1] = 1'b1; tile_int_req[0] = 1'b1;
    step();
    chk("nmi_pin", {31'h0, cpu_nmi}, 32'h1);
    chk("nmi_noint", {30'h0, cpu_int}, 32'h0);
    ack_chk("nmi_ack", 3'b000);
    tile_nmi_req[1] = 1'b0;
    step();
    chk("nmi_next", {29'h0, cpu_int, cpu_nmi}, 32'b010);
    tile_int_req[0] = 1'b0;
    step();
    chk("nmi_idle", {29'h0, cpu_int, cpu_nmi}, 32'h0);
    wr(8'd7, 32'h0);

    // two INTs: lowest first, then handoff to slot 1 pin 1
    wr(8'd2, 32'h81);
    tile_int_req[0] = 1'b1; tile_int_req[2] = 1'b1;
    step();
    chk("two_first", {30'h0, cpu_int}, 32'b01);
    tile_int_req[0] = 1'b0;
    step();
    chk("two_second", {30'h0, cpu_int}, 32'b10);
    chk("two_slot", {30'h0, irq_int_slot}, 32'h1);
    ack_chk("two_ack", 3'b010);
    tile_int_req[2] = 1'b0;
    step();
    chk("two_idle", {30'h0, cpu_int}, 32'h0);

    // a short pulse while busy is lost
    tile_int_req[0] = 1'b1;
    step();
    tile_int_req[2] = 1'b1;
    step();
    tile_int_req[2] = 1'b0;
    chk("pulse_busy", {30'h0, cpu_int}, 32'b01);
    tile_int_req[0] = 1'b0;
    step();
    chk("pulse_lost", {31'h0, irq_int_active}, 32'h0);
    step();
    chk("pulse_lost2", {30'h0, cpu_int}, 32'h0);

    // disabling the active entry releases one edge after the write edge
    tile_int_req[0] = 1'b1;
    step();
    wr(8'd0, 32'h0);
    chk("dis_wr_edge", {30'h0, cpu_int}, 32'b01);
    step();
    chk("dis_release", {30'h0, cpu_int}, 32'h0);
    tile_int_req[0] = 1'b0;

    // out-of-range pin index still occupies and acks; disabled pending never runs
    wr(8'd0, 32'h83);
    tile_int_req[0] = 1'b1;
    step();
    chk("oor_pin", {30'h0, cpu_int}, 32'h0);
    chk("oor_act", {31'h0, irq_int_active}, 32'h1);
    ack_chk("oor_ack", 3'b001);
    tile_int_req[2] = 1'b1;
    step();
    chk("oor_block", {31'h0, irq_int_active, cpu_int[1]}, 32'b10);
    wr(8'd2, 32'h0);
    tile_int_req[0] = 1'b0;
    step();
    chk("dis_pend", {29'h0, irq_int_active, cpu_int}, 32'h0);
    step();
    chk("dis_pend2", {29'h0, irq_int_active, cpu_int}, 32'h0);
    tile_int_req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
